// File: rtl/voice_mixer_if.sv
// voice_mixer_if: tick/voice snapshot inputs and valid/ready mixed-sample output of voice_mixer.
// Peak meter signals exist only when VOICE_MIXER_PEAK_METER_EN is defined.
interface voice_mixer_if #(
   parameter int NUM_VOICES = 16,
   parameter int WIDTH      = 24,
   parameter int VOL_WIDTH  = 8
);
   logic                        sample_tick;
   logic [NUM_VOICES*WIDTH-1:0] voice_in;
   logic [NUM_VOICES-1:0]       voice_enable;
   logic [VOL_WIDTH:0]          master_vol;
   logic [WIDTH-1:0]            out_sample;
   logic                        out_valid;
   logic                        out_ready;
   logic                        busy;
   logic                        overrun;
`ifdef VOICE_MIXER_PEAK_METER_EN
   logic                        peak_clear;
   logic [WIDTH-2:0]            peak_level;
   modport master (output sample_tick, voice_in, voice_enable, master_vol, out_ready, peak_clear,
                   input  out_sample, out_valid, busy, overrun, peak_level);
   modport slave  (input  sample_tick, voice_in, voice_enable, master_vol, out_ready, peak_clear,
                   output out_sample, out_valid, busy, overrun, peak_level);
`else
   modport master (output sample_tick, voice_in, voice_enable, master_vol, out_ready,
                   input  out_sample, out_valid, busy, overrun);
   modport slave  (input  sample_tick, voice_in, voice_enable, master_vol, out_ready,
                   output out_sample, out_valid, busy, overrun);
`endif
endinterface

// File: rtl/voice_mixer.sv
// voice_mixer: sums enabled voices one per cycle, applies master volume, saturates, valid/ready out.
// Optional peak meter: define VOICE_MIXER_PEAK_METER_EN.
module voice_mixer #(
   parameter int NUM_VOICES = 16,
   parameter int WIDTH      = 24,
   parameter int VOL_WIDTH  = 8
) (
   input logic           clk,
   input logic           rstn,
   voice_mixer_if.slave  bus
);
   localparam int IW = $clog2(NUM_VOICES);
   localparam int AW = WIDTH + IW;
   localparam int PW = AW + VOL_WIDTH + 2;
   localparam int SW = PW - VOL_WIDTH;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ACCUM = 3'd1;
   localparam logic [2:0] S_SCALE = 3'd2;
   localparam logic [2:0] S_SAT   = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;
   localparam logic [VOL_WIDTH:0] UNITY = {1'b1, {VOL_WIDTH{1'b0}}};

   logic [2:0]                  state_q, state_d;
   logic [NUM_VOICES*WIDTH-1:0] voice_q, voice_d;
   logic [NUM_VOICES-1:0]       en_q, en_d;
   logic [VOL_WIDTH:0]          vol_q, vol_d;
   logic signed [AW-1:0]        acc_q, acc_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic signed [SW-1:0]        scaled_q, scaled_d;
   logic [WIDTH-1:0]            out_q, out_d;
   logic                        valid_q, valid_d;
   logic                        ovr_q, ovr_d;
   logic signed [WIDTH-1:0]     voice_sel;
   logic signed [PW-1:0]        prod;
   logic [SW-WIDTH:0]           hi;
   logic [WIDTH-1:0]            sat;

   assign voice_sel = $signed(voice_q[idx_q*WIDTH +: WIDTH]);
   assign prod      = acc_q * $signed({1'b0, vol_q});
   assign hi        = scaled_q[SW-1:WIDTH-1];
   // In range when every bit above the result's sign bit matches it
   assign sat       = (&hi || !(|hi)) ? scaled_q[WIDTH-1:0]
                    : (scaled_q[SW-1] ? {1'b1, {WIDTH-1{1'b0}}} : {1'b0, {WIDTH-1{1'b1}}});

   always_comb begin
      state_d  = state_q;
      voice_d  = voice_q;
      en_d     = en_q;
      vol_d    = vol_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      scaled_d = scaled_q;
      out_d    = out_q;
      valid_d  = valid_q;
      ovr_d    = bus.sample_tick && state_q != S_IDLE;
      case (state_q)
         S_IDLE: if (bus.sample_tick) begin
            voice_d = bus.voice_in;
            en_d    = bus.voice_enable;
            vol_d   = bus.master_vol > UNITY ? UNITY : bus.master_vol;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_ACCUM;
         end
         S_ACCUM: begin
            acc_d   = acc_q + (en_q[idx_q] ? AW'(voice_sel) : AW'(0));
            idx_d   = idx_q + 1'b1;
            state_d = idx_q == IW'(NUM_VOICES - 1) ? S_SCALE : S_ACCUM;
         end
         S_SCALE: begin
            scaled_d = SW'(prod >>> VOL_WIDTH);
            state_d  = S_SAT;
         end
         S_SAT: begin
            out_d   = sat;
            valid_d = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: if (bus.out_ready) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         voice_q  <= '0;
         en_q     <= '0;
         vol_q    <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         scaled_q <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         voice_q  <= voice_d;
         en_q     <= en_d;
         vol_q    <= vol_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         scaled_q <= scaled_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign bus.out_sample = out_q;
   assign bus.out_valid  = valid_q;
   assign bus.busy       = state_q != S_IDLE;
   assign bus.overrun    = ovr_q;

`ifdef VOICE_MIXER_PEAK_METER_EN
   logic [WIDTH-2:0] peak_q, peak_d, mag;
   // The most negative sample has no positive twin, so it reads as full scale
   assign mag = !sat[WIDTH-1] ? sat[WIDTH-2:0]
              : (sat[WIDTH-2:0] == '0 ? {WIDTH-1{1'b1}} : (WIDTH-1)'(-sat));
   assign peak_d = bus.peak_clear ? '0 : (state_q == S_SAT && mag > peak_q) ? mag : peak_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) peak_q <= '0;
      else peak_q <= peak_d;
   end
   assign bus.peak_level = peak_q;
`endif
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: table-driven mix vectors with a sample scoreboard, plus back-pressure,
// overrun, mid-mix reset and (when VOICE_MIXER_PEAK_METER_EN is defined) peak meter sequences.
module tb_voice_mixer;
   localparam int NV = 4;
   localparam int W  = 24;
   localparam int VW = 8;

   typedef struct {
      logic [NV*W-1:0] v;
      logic [NV-1:0]   en;
      int              vol;
      int              exp;
   } vec_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   q[$];
   vec_t tbl[10];

   voice_mixer_if #(.NUM_VOICES(NV), .WIDTH(W), .VOL_WIDTH(VW)) bus ();
   voice_mixer #(.NUM_VOICES(NV), .WIDTH(W), .VOL_WIDTH(VW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic logic [NV*W-1:0] pack(input int a, input int b, input int c, input int d);
      return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
   endfunction

   always @(negedge clk) begin
      if (rstn && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) check("unexpected_sample", $signed(bus.out_sample), 0);
         else check("sample", $signed(bus.out_sample), q.pop_front());
      end
   end

   task automatic drive(input vec_t t);
      bus.voice_in     = t.v;
      bus.voice_enable = t.en;
      bus.master_vol   = 9'(t.vol);
   endtask

   task automatic scramble();
      bus.voice_in     = {$urandom, $urandom, $urandom};
      bus.voice_enable = 4'($urandom);
      bus.master_vol   = 9'($urandom);
   endtask

   // Tick captured at the next posedge, inputs scrambled right after to prove snapshotting.
   task automatic tick(input vec_t t);
      @(posedge clk); #2;
      drive(t);
      bus.sample_tick = 1'b1;
      q.push_back(t.exp);
      @(posedge clk); #2;
      bus.sample_tick = 1'b0;
      scramble();
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && bus.busy; i++) begin
         @(posedge clk); #2;
      end
   endtask

   int cyc, bad_valid, bad_busy, bad_out, ovr_seen, stable_bad, extra;
   logic [W-1:0] held;

   initial begin
      tbl[0] = '{pack(1000, -200, 300, 50), 4'b1111, 256, 1150};
      tbl[1] = '{pack(1000, -200, 300, 50), 4'b0101, 128, 650};
      tbl[2] = '{pack(1000, -200, 300, 50), 4'b0101, 300, 1300};
      tbl[3] = '{pack(8388607, 8388607, 8388607, 8388607), 4'b1111, 256, 8388607};
      tbl[4] = '{pack(-8388608, -8388608, -8388608, -8388608), 4'b1111, 256, -8388608};
      tbl[5] = '{pack(-3, 0, 0, 0), 4'b0001, 128, -2};
      tbl[6] = '{pack(1000, -200, 300, 50), 4'b0000, 256, 0};
      tbl[7] = '{pack(1000, -200, 300, 50), 4'b1111, 0, 0};
      tbl[8] = '{pack(-1, -1, -1, -1), 4'b1111, 1, -1};
      tbl[9] = '{pack(8388607, 8388607, 8388607, 8388607), 4'b1111, 128, 8388607};
      bus.sample_tick = 1'b0;
      bus.out_ready   = 1'b1;
`ifdef VOICE_MIXER_PEAK_METER_EN
      bus.peak_clear  = 1'b0;
`endif
      scramble();
      #23 rstn = 1'b1;

      bad_valid = 0; bad_busy = 0; bad_out = 0; ovr_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         bad_valid += int'(bus.out_valid !== 1'b0);
         bad_busy  += int'(bus.busy !== 1'b0);
         bad_out   += int'(bus.out_sample !== '0);
         ovr_seen  += int'(bus.overrun !== 1'b0);
      end
      check("reset_out_valid", bad_valid, 0);
      check("reset_busy", bad_busy, 0);
      check("reset_out_sample", bad_out, 0);
      check("reset_overrun", ovr_seen, 0);

      foreach (tbl[i]) begin
         tick(tbl[i]);
         wait_valid(cyc);
         check($sformatf("latency_vec%0d", i), cyc, NV + 3);
         wait_idle();
      end

      // Back-pressure: held output, one dropped tick, then a tick in the handshake cycle.
      bus.out_ready = 1'b0;
      tick(tbl[0]);
      wait_valid(cyc);
      check("latency_held", cyc, NV + 3);
      held = bus.out_sample;
      stable_bad = 0; ovr_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         bus.sample_tick = (i == 3);
         if (i == 3) drive(tbl[3]);
         @(negedge clk);
         stable_bad += int'(!bus.out_valid || bus.out_sample !== held);
         ovr_seen   += int'(bus.overrun === 1'b1);
      end
      check("held_stable", stable_bad, 0);
      check("overrun_pulses", ovr_seen, 1);
      @(posedge clk); #2;
      bus.out_ready   = 1'b1;
      bus.sample_tick = 1'b1;
      @(posedge clk); #2;
      bus.sample_tick = 1'b0;
      @(negedge clk);
      check("overrun_at_handshake", int'(bus.overrun), 1);
      check("valid_after_handshake", int'(bus.out_valid), 0);
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         extra += int'(bus.out_valid === 1'b1);
      end
      check("no_extra_sample", extra, 0);
      check("idle_after_drop", int'(bus.busy), 0);

      // Reset during ACCUM aborts the mix and clears the previous sample.
      tick(tbl[3]);
      @(posedge clk); #2;
      rstn = 1'b0;
      void'(q.pop_back());
      #1;
      check("abort_out_sample", $signed(bus.out_sample), 0);
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_busy", int'(bus.busy), 0);
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      tick(tbl[1]);
      wait_valid(cyc);
      check("latency_after_reset", cyc, NV + 3);
      wait_idle();

`ifdef VOICE_MIXER_PEAK_METER_EN
      tick('{pack(500, 0, 0, 0), 4'b0001, 256, 500});
      wait_valid(cyc); wait_idle();
      tick('{pack(-900, 0, 0, 0), 4'b0001, 256, -900});
      wait_valid(cyc); wait_idle();
      tick('{pack(200, 0, 0, 0), 4'b0001, 256, 200});
      wait_valid(cyc); wait_idle();
      @(negedge clk);
      check("peak_max", int'(bus.peak_level), 900);
      @(posedge clk); #2 bus.peak_clear = 1'b1;
      @(posedge clk); #2 bus.peak_clear = 1'b0;
      @(negedge clk);
      check("peak_cleared", int'(bus.peak_level), 0);
      tick('{pack(200, 0, 0, 0), 4'b0001, 256, 200});
      wait_valid(cyc); wait_idle();
      @(negedge clk);
      check("peak_after_clear", int'(bus.peak_level), 200);
      tick(tbl[4]);
      wait_valid(cyc); wait_idle();
      @(negedge clk);
      check("peak_most_negative", int'(bus.peak_level), 8388607);
`endif

      repeat (5) @(negedge clk);
      check("scoreboard_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
